// File: rtl/long_stack_pkg.sv
// Shared types and width helpers for the bounded monotonic stack.
// DATA_WIDTH falls back to 8 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package long_stack_pkg;
  typedef logic [`DATA_WIDTH-1:0] data_t;

  // Width of a count that can hold 0..cap inclusive.
  function automatic int size_w(input int cap);
    return $clog2(cap) + 1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/long_stack_popcalc.sv
// Pop-count scan: walks down from the top and stops at the first entry that
// is not smaller than data_in or whose removal would leave too few slots fillable.
module long_stack_popcalc
  import long_stack_pkg::*;
#(
  parameter int MAX_CAP = 4,
  parameter int SW      = 3
) (
  input  data_t           entries [MAX_CAP],
  input  logic [SW-1:0]   size,
  input  data_t           data_in,
  input  data_t           nums_left,
  output logic [SW-1:0]   k
);
  localparam int DW = $bits(data_t);
  localparam int CW = max_i(DW, SW) + 1;
  localparam int IW = (MAX_CAP > 1) ? $clog2(MAX_CAP) : 1;

  logic          go;
  logic [CW-1:0] below;

  // below = entries left under slot i; only meaningful when i < size
  always_comb begin
    k     = '0;
    go    = 1'b1;
    below = '0;
    for (int i = 0; i < MAX_CAP; i++) begin
      below = CW'(size) - CW'(i) - CW'(1);
      if (go && (CW'(i) < CW'(size)) &&
          (entries[below[IW-1:0]] < data_in) &&
          ((below + CW'(nums_left)) >= CW'(MAX_CAP)))
        k = SW'(i + 1);
      else
        go = 1'b0;
    end
  end
endmodule

// File: rtl/long_stack.sv
// Greedy max-subsequence stack: one value per cycle, multi-pop then push.
// Define LONG_STACK_DUMP_EN to expose the entry array as stack_flat.
module long_stack
  import long_stack_pkg::*;
#(
  parameter int MAX_CAP = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in_valid,
  input  logic [`DATA_WIDTH-1:0]     data_in,
  input  logic [`DATA_WIDTH-1:0]     nums_left,
`ifdef LONG_STACK_DUMP_EN
  output logic [MAX_CAP*`DATA_WIDTH-1:0] stack_flat,
`endif
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(MAX_CAP):0]   size
);
  localparam int SW = size_w(MAX_CAP);
  localparam int DW = $bits(data_t);
  localparam int IW = (MAX_CAP > 1) ? $clog2(MAX_CAP) : 1;

  data_t         entries [MAX_CAP];
  logic [SW-1:0] count;
  logic [SW-1:0] k;
  logic [SW-1:0] after;
  logic          push;

  long_stack_popcalc #(.MAX_CAP(MAX_CAP), .SW(SW)) u_popcalc (
    .entries  (entries),
    .size     (count),
    .data_in  (data_in),
    .nums_left(nums_left),
    .k        (k)
  );

  assign after = count - k;
  assign push  = after < SW'(MAX_CAP);

  // Popped slots are simply overwritten later; no clearing needed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < MAX_CAP; i++) entries[i] <= '0;
    end else if (data_in_valid && push) begin
      entries[after[IW-1:0]] <= data_in;
      count                  <= after + SW'(1);
    end
  end

  assign size  = count;
  assign full  = (count == SW'(MAX_CAP));
  assign empty = (count == '0);

`ifdef LONG_STACK_DUMP_EN
  for (genvar gi = 0; gi < MAX_CAP; gi++) begin : g_dump
    assign stack_flat[gi*DW +: DW] = entries[gi];
  end
`endif
endmodule

// File: tb/tb_long_stack.sv
// Directed bench for long_stack (MAX_CAP=4); contents read via stack_flat
// when LONG_STACK_DUMP_EN is defined, otherwise via the entry array.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_long_stack;
  localparam int W = `DATA_WIDTH;
  localparam int CAP = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             data_in_valid = 1'b0;
  logic [W-1:0]     data_in = '0;
  logic [W-1:0]     nums_left = '0;
  logic             full, empty;
  logic [2:0]       size;
  logic [CAP*W-1:0] view;

  int checks = 0;
  int failures = 0;

`ifdef LONG_STACK_DUMP_EN
  logic [CAP*W-1:0] stack_flat;
  assign view = stack_flat;
`else
  always_comb begin
    view = '0;
    for (int i = 0; i < CAP; i++) view[i*W +: W] = dut.entries[i];
  end
`endif

  long_stack #(.MAX_CAP(CAP)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in_valid(data_in_valid),
    .data_in      (data_in),
    .nums_left    (nums_left),
`ifdef LONG_STACK_DUMP_EN
    .stack_flat   (stack_flat),
`endif
    .full         (full),
    .empty        (empty),
    .size         (size)
  );

  always #5 clock = ~clock;

  function automatic logic [CAP*W-1:0] pack(input int e0, e1, e2, e3);
    return {W'(e3), W'(e2), W'(e1), W'(e0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp_size, input logic [CAP*W-1:0] exp_stack);
    check({tag, ".size"},  64'(size),  64'(exp_size));
    check({tag, ".full"},  64'(full),  64'(exp_size == CAP));
    check({tag, ".empty"}, 64'(empty), 64'(exp_size == 0));
    check({tag, ".stack"}, 64'(view),  64'(exp_stack));
  endtask

  // Inputs change 1 time unit after the edge; sampling happens there too.
  task automatic feed(input int d, input int nl);
    data_in_valid = 1'b1;
    data_in       = W'(d);
    nums_left     = W'(nl);
    @(posedge clock); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    // 1: reset
    do_reset();
    check_state("reset", 0, pack(0, 0, 0, 0));

    // 2: fill with descending values
    feed(30, 8); check_state("push30", 1, pack(30, 0, 0, 0));
    feed(27, 8); check_state("push27", 2, pack(30, 27, 0, 0));
    feed(25, 8); check_state("push25", 3, pack(30, 27, 25, 0));
    feed(20, 8); check_state("push20", 4, pack(30, 27, 25, 20));

    // 3: smaller value on a full stack is dropped
    feed(16, 8); check_state("drop16", 4, pack(30, 27, 25, 20));

    // 4: 25 pops 20 only; equal 25 never pops
    feed(25, 8); check_state("pop20", 4, pack(30, 27, 25, 25));
    feed(25, 8); check_state("eq25", 4, pack(30, 27, 25, 25));

    // nums_left=0 inhibits pops; idle cycles change nothing
    feed(99, 0); check_state("nl0", 4, pack(30, 27, 25, 25));
    data_in = 8'd200; nums_left = 8'd8;
    @(posedge clock); #1;
    check_state("idle", 4, pack(30, 27, 25, 25));

    // multi-pop: 9,5,3 then 7 pops 3 and 5, stops at 9
    do_reset();
    feed(9, 8); feed(5, 8); feed(3, 8);
    check_state("pre_multi", 3, pack(9, 5, 3, 0));
    feed(7, 8); check_state("multi_pop", 2, pack(9, 7, 3, 0));

    // 5: remaining-count limit: 30 with nums_left=3 may pop 20 but not 10
    do_reset();
    feed(10, 2); feed(20, 2);
    check_state("pre_limit", 2, pack(10, 20, 0, 0));
    feed(30, 3); check_state("limit_pop1", 2, pack(10, 30, 0, 0));
    // with nums_left=1 even the top cannot be popped
    feed(40, 1); check_state("limit_pop0", 3, pack(10, 30, 40, 0));

    // 6: async reset between edges clears outputs before the next edge
    #2 reset = 1'b0;
    #1 check_state("async_rst", 0, pack(0, 0, 0, 0));
    @(posedge clock); #1 reset = 1'b1;
    feed(42, 8); check_state("restart", 1, pack(42, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
